// File: rtl/cnn_pkg.sv
// Shared definitions for the convolution layer: operand width default, MAC depth
// and the scheduler state encoding.
package cnn_pkg;

    localparam int DEF_WIDTH = 8;
    localparam int MAC_LAT   = 6;
    localparam int N_TAPS    = 9;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD_W,
        ST_RUN,
        ST_DRAIN,
        ST_DONE
    } sched_state_t;

endpackage

// File: rtl/valid_tag_pipe.sv
// DEPTH-deep 1-bit shift register tracking which MAC pipeline slots carry a real
// window; tail marks a result leaving the pipe, any_set shows work still in flight.
module valid_tag_pipe #(
    parameter int DEPTH = 7
) (
    input  logic clk,
    input  logic rst_n,
    input  logic push,
    output logic tail,
    output logic any_set
);

    logic [DEPTH-1:0] tag;

    // NOTE: sequential state uses non-blocking assignment so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tag <= '0;
        end else begin
            tag <= {tag[DEPTH-2:0], push};
        end
    end

    assign tail    = tag[DEPTH-1];
    assign any_set = |tag;

endmodule

// File: rtl/conv3x3_mac_sched.sv
// Sequencer for the 3x3 signed MAC: loads the kernel, streams windows with
// calculate-enable held for the whole map, then drains and tags results.
module conv3x3_mac_sched
    import cnn_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int OUT_W = 26,
    parameter int OUT_H = 26,
    parameter int LAT   = MAC_LAT + 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start,
    output logic                     busy,
    output logic                     done,
    input  logic                     w_valid,
    output logic                     w_ready,
    input  logic [WIDTH-1:0]         w_data,
    input  logic                     win_valid,
    output logic                     win_ready,
    input  logic [N_TAPS*WIDTH-1:0]  win_data,
    output logic                     mac_cal_valid,
    output logic [N_TAPS*WIDTH-1:0]  mac_win,
    output logic [N_TAPS*WIDTH-1:0]  mac_wgt,
    input  logic [2*WIDTH-1:0]       mac_dout,
    output logic                     res_valid,
    output logic [2*WIDTH-1:0]       res_data
);

    localparam int N_OUT = OUT_W * OUT_H;
    localparam int CNT_W = $clog2(N_OUT + 1);

    sched_state_t     state, state_nxt;
    logic [3:0]       tap_cnt;
    logic [CNT_W-1:0] win_cnt;
    logic [CNT_W-1:0] res_cnt;
    logic             w_fire;
    logic             win_fire;
    logic             tag_tail;
    logic             tag_any;

    // Handshakes decode the state directly so the ready outputs never loop back.
    assign w_fire   = w_valid   && (state == ST_LOAD_W);
    assign win_fire = win_valid && (state == ST_RUN);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // NOTE: every combinational output gets a default first, so no path can infer a latch.
    always_comb begin
        state_nxt     = state;
        busy          = 1'b1;
        done          = 1'b0;
        w_ready       = 1'b0;
        win_ready     = 1'b0;
        mac_cal_valid = 1'b0;
        unique case (state)
            ST_IDLE: begin
                busy = 1'b0;
                if (start) state_nxt = ST_LOAD_W;
            end
            ST_LOAD_W: begin
                w_ready = 1'b1;
                if (w_fire && tap_cnt == 4'(N_TAPS - 1)) state_nxt = ST_RUN;
            end
            ST_RUN: begin
                win_ready     = 1'b1;
                mac_cal_valid = 1'b1;
                if (win_fire && win_cnt == CNT_W'(N_OUT - 1)) state_nxt = ST_DRAIN;
            end
            ST_DRAIN: begin
                mac_cal_valid = 1'b1;
                if (res_cnt == CNT_W'(N_OUT) && !tag_any) state_nxt = ST_DONE;
            end
            ST_DONE: begin
                done      = 1'b1;
                state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // res_cnt advances with the same edge that raises res_valid, so the drain
    // exit sees the final count together with an empty tag pipe.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tap_cnt <= '0;
            win_cnt <= '0;
            res_cnt <= '0;
        end else if (state == ST_IDLE && start) begin
            tap_cnt <= '0;
            win_cnt <= '0;
            res_cnt <= '0;
        end else begin
            if (w_fire)   tap_cnt <= tap_cnt + 4'd1;
            if (win_fire) win_cnt <= win_cnt + CNT_W'(1);
            if (tag_tail) res_cnt <= res_cnt + CNT_W'(1);
        end
    end

    // NOTE: kernel and window registers are plain flops, so they take the async reset like any other state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mac_wgt <= '0;
        end else begin
            for (int k = 0; k < N_TAPS; k++) begin
                if (w_fire && tap_cnt == 4'(k)) mac_wgt[k*WIDTH +: WIDTH] <= w_data;
            end
        end
    end

    // Bubbles keep the previous window; the tag pipe marks them as non-results.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mac_win <= '0;
        end else if (win_fire) begin
            mac_win <= win_data;
        end
    end

    valid_tag_pipe #(
        .DEPTH (LAT)
    ) u_tag_pipe (
        .clk     (clk),
        .rst_n   (rst_n),
        .push    (win_fire),
        .tail    (tag_tail),
        .any_set (tag_any)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            res_valid <= 1'b0;
            res_data  <= '0;
        end else begin
            res_valid <= tag_tail;
            res_data  <= mac_dout;
        end
    end

endmodule

// File: tb/tb_conv3x3_mac_sched.sv
// Scoreboard bench for conv3x3_mac_sched: a 6-stage flipped-kernel MAC model feeds
// mac_dout, and a window-level reference predicts every result and its timing.
module tb_conv3x3_mac_sched;

    localparam int WIDTH      = 8;
    localparam int OUT_W      = 2;
    localparam int OUT_H      = 2;
    localparam int LAT        = 7;
    localparam int N          = OUT_W * OUT_H;
    localparam int MAC_STAGES = 6;

    logic                   clk = 1'b0;
    logic                   rst_n = 1'b0;
    logic                   start = 1'b0;
    logic                   busy, done;
    logic                   w_valid = 1'b0;
    logic                   w_ready;
    logic [WIDTH-1:0]       w_data = '0;
    logic                   win_valid = 1'b0;
    logic                   win_ready;
    logic [9*WIDTH-1:0]     win_data = '0;
    logic                   mac_cal_valid;
    logic [9*WIDTH-1:0]     mac_win, mac_wgt;
    logic [2*WIDTH-1:0]     mac_dout;
    logic                   res_valid;
    logic [2*WIDTH-1:0]     res_data;

    conv3x3_mac_sched #(
        .WIDTH (WIDTH),
        .OUT_W (OUT_W),
        .OUT_H (OUT_H),
        .LAT   (LAT)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .start         (start),
        .busy          (busy),
        .done          (done),
        .w_valid       (w_valid),
        .w_ready       (w_ready),
        .w_data        (w_data),
        .win_valid     (win_valid),
        .win_ready     (win_ready),
        .win_data      (win_data),
        .mac_cal_valid (mac_cal_valid),
        .mac_win       (mac_win),
        .mac_wgt       (mac_wgt),
        .mac_dout      (mac_dout),
        .res_valid     (res_valid),
        .res_data      (res_data)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [71:0] act, input logic [71:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // External MAC: six stages, kernel applied flipped, cleared when calculate-enable drops.
    function automatic logic [2*WIDTH-1:0] mac_dot(input logic [9*WIDTH-1:0] win,
                                                   input logic [9*WIDTH-1:0] wgt);
        int acc;
        acc = 0;
        for (int i = 0; i < 9; i++)
            acc += int'($signed(win[i*WIDTH +: WIDTH])) * int'($signed(wgt[(8-i)*WIDTH +: WIDTH]));
        return acc[2*WIDTH-1:0];
    endfunction

    logic [2*WIDTH-1:0] mac_pipe [MAC_STAGES];
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n || !mac_cal_valid) begin
            for (int i = 0; i < MAC_STAGES; i++) mac_pipe[i] <= '0;
        end else begin
            mac_pipe[0] <= mac_dot(mac_win, mac_wgt);
            for (int i = 1; i < MAC_STAGES; i++) mac_pipe[i] <= mac_pipe[i-1];
        end
    end
    assign mac_dout = mac_pipe[MAC_STAGES-1];

    // Reference model: the kernel and pixels the bench sent, as plain integers.
    int kern [9];
    int pix  [9];

    function automatic logic [2*WIDTH-1:0] ref_conv();
        int acc;
        acc = 0;
        for (int i = 0; i < 9; i++) acc += pix[i] * kern[8-i];
        return 16'(acc);
    endfunction

    function automatic logic [9*WIDTH-1:0] pack_kern();
        logic [9*WIDTH-1:0] v;
        for (int k = 0; k < 9; k++) v[k*WIDTH +: WIDTH] = kern[k][WIDTH-1:0];
        return v;
    endfunction

    typedef struct {
        logic [2*WIDTH-1:0] data;
        int                 hs;
    } exp_t;

    exp_t sb[$];
    int   last_res_cyc = 0;
    bit   cal_drop = 1'b0;

    // Monitor: pops one expectation per res_valid, checks value and latency.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n) begin
            if (!mac_cal_valid && (win_ready || sb.size() != 0)) cal_drop = 1'b1;
            if (res_valid) begin
                if (sb.size() == 0) begin
                    check("res_unexpected", {71'd0, res_valid}, 72'd0);
                end else begin
                    e = sb.pop_front();
                    check("res_data", {56'd0, res_data}, {56'd0, e.data});
                    check("res_latency", 72'(cyc - e.hs), 72'(LAT));
                    last_res_cyc = cyc;
                end
            end
        end
    end

    task automatic load_kernel(input bit rnd_gaps);
        int k = 0;
        int it = 0;
        while (k < 9 && it < 200) begin
            @(negedge clk);
            start   = 1'b0;
            w_valid = rnd_gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
            w_data  = kern[k][WIDTH-1:0];
            if (w_valid && w_ready) k++;
            it++;
        end
        check("tap_accept_count", 72'(k), 72'd9);
        @(posedge clk);
        #1;
        w_valid = 1'b0;
        check("mac_wgt_slots", mac_wgt, pack_kern());
    endtask

    task automatic send_windows(input int gap_mode, input logic [31:0] pat, input int plen,
                                input int pix_mode, input int pix_val, input bit poke_start,
                                input int count);
        int w = 0;
        int it = 0;
        while (w < count && it < 500) begin
            @(negedge clk);
            start = poke_start && (it == 1);
            case (gap_mode)
                1:       win_valid = (it < plen) ? pat[it] : 1'b1;
                2:       win_valid = ($urandom_range(0, 2) != 0);
                default: win_valid = 1'b1;
            endcase
            for (int i = 0; i < 9; i++) begin
                pix[i] = (pix_mode == 0) ? pix_val : int'($urandom_range(0, 255)) - 128;
                win_data[i*WIDTH +: WIDTH] = pix[i][WIDTH-1:0];
            end
            if (win_valid && win_ready) begin
                sb.push_back('{ref_conv(), cyc + 1});
                w++;
            end
            it++;
        end
        check("win_accept_count", 72'(w), 72'(count));
        @(posedge clk);
        #1;
        win_valid = 1'b0;
        start     = 1'b0;
    endtask

    task automatic wait_done();
        int it = 0;
        @(negedge clk);
        while (!done && it < 300) begin
            @(negedge clk);
            it++;
        end
        check("done_busy_seen", {70'd0, done, busy}, 72'd3);
        check("done_after_last_res", 72'(cyc), 72'(last_res_cyc + 1));
        check("results_outstanding", 72'(sb.size()), 72'd0);
        check("cal_valid_held", {71'd0, cal_drop}, 72'd0);
        @(negedge clk);
        check("idle_after_done", {67'd0, done, busy, w_ready, win_ready, mac_cal_valid}, 72'd0);
    endtask

    task automatic set_kernel(input int kmode, input int kval);
        for (int k = 0; k < 9; k++)
            kern[k] = (kmode == 0) ? kval : (kmode == 1) ? k + 1 : int'($urandom_range(0, 255)) - 128;
    endtask

    // Stray valids in IDLE must not be accepted; then pulse start.
    task automatic begin_job();
        cal_drop = 1'b0;
        @(negedge clk);
        w_valid   = 1'b1;
        win_valid = 1'b1;
        #1;
        check("idle_ready_low", {70'd0, w_ready, win_ready}, 72'd0);
        w_valid   = 1'b0;
        win_valid = 1'b0;
        start     = 1'b1;
    endtask

    task automatic run_job(input int kmode, input int kval, input int pix_mode, input int pix_val,
                           input int gap_mode, input logic [31:0] pat, input int plen,
                           input bit poke_start);
        set_kernel(kmode, kval);
        begin_job();
        load_kernel(gap_mode == 2);
        send_windows(gap_mode, pat, plen, pix_mode, pix_val, poke_start, N);
        wait_done();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int stray;
        #1;
        check("reset_ctrl", {66'd0, busy, done, w_ready, win_ready, mac_cal_valid, res_valid}, 72'd0);
        check("reset_mac_win", mac_win, 72'd0);
        check("reset_mac_wgt", mac_wgt, 72'd0);
        check("reset_res_data", {56'd0, res_data}, 72'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        run_job(1, 0, 0, 2, 0, 32'h0, 0, 1'b0);        // taps 1..9, pixels 2 -> 90
        run_job(0, -1, 0, 5, 0, 32'h0, 0, 1'b0);       // -45
        run_job(2, 0, 1, 0, 1, 32'h69, 7, 1'b0);       // valid 1,0,0,1,0,1,1
        run_job(0, -128, 0, -128, 0, 32'h0, 0, 1'b0);  // wraps to 16384
        run_job(2, 0, 1, 0, 0, 32'h0, 0, 1'b1);        // start pulsed in RUN
        repeat (3) run_job(2, 0, 1, 0, 2, 32'h0, 0, 1'b0);

        // Reset after two of four windows have been accepted.
        set_kernel(2, 0);
        begin_job();
        load_kernel(1'b0);
        send_windows(0, 32'h0, 0, 1, 0, 1'b0, 2);
        #1;
        rst_n = 1'b0;
        #1;
        check("midrun_reset_ctrl", {66'd0, busy, done, w_ready, win_ready, mac_cal_valid, res_valid}, 72'd0);
        check("midrun_reset_mac_win", mac_win, 72'd0);
        check("midrun_reset_mac_wgt", mac_wgt, 72'd0);
        check("midrun_reset_res_data", {56'd0, res_data}, 72'd0);
        sb.delete();
        @(negedge clk);
        rst_n = 1'b1;
        stray = 0;
        repeat (20) begin
            @(negedge clk);
            if (res_valid) stray++;
        end
        check("no_res_after_reset", 72'(stray), 72'd0);
        run_job(2, 0, 1, 0, 0, 32'h0, 0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
